// File: rtl/tlul_peri_responder.sv
// TL-UL device endpoint: each request becomes one register strobe and one D response.
// Strobe at N+1, d_valid at N+2 plus busy cycles; a_ready low outside IDLE, D fields held until d_ready.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam logic [15:0] TlUserDefault = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_peri_responder #(
  parameter int AW            = 12,
  parameter int TimeoutCycles = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              re_o,
  output logic              we_o,
  output logic [AW-1:0]     addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        be_o,
  input  logic              busy_i,
  input  logic [31:0]       rdata_i,
  input  logic              error_i
);
  import tlul_pkg::*;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Busy cycle on which the counter would reach TimeoutCycles.
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);

  state_e      state_q;
  logic        is_get_q;
  logic [15:0] tmo_cnt_q;
  logic        d_valid_q;
  logic        d_error_q;
  logic [2:0]  d_opcode_q;
  logic [1:0]  d_size_q;
  logic [7:0]  d_source_q;
  logic [31:0] d_data_q;

  logic        a_get;
  logic [3:0]  lanes;
  logic        misaligned;
  logic        proto_err;
  logic        unused_tl;

  assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:AW]};

  assign a_get = (tl_i.a_opcode == Get);

  always_comb begin
    lanes = 4'b0000;
    case (tl_i.a_size)
      2'd0:    lanes = 4'b0001 << tl_i.a_address[1:0];
      2'd1:    lanes = 4'b0011 << tl_i.a_address[1:0];
      2'd2:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  assign misaligned = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                      ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));

  assign proto_err = !((tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData) || a_get)
                   || (tl_i.a_size == 2'd3)
                   || misaligned
                   || ((tl_i.a_mask & ~lanes) != 4'b0000)
                   || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != lanes));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      is_get_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      re_o       <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      be_o       <= '0;
      d_valid_q  <= 1'b0;
      d_error_q  <= 1'b0;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tl_i.a_valid) begin
            is_get_q   <= a_get;
            d_opcode_q <= a_get ? AccessAckData : AccessAck;
            d_size_q   <= tl_i.a_size;
            d_source_q <= tl_i.a_source;
            addr_o     <= {tl_i.a_address[AW-1:2], 2'b00};
            wdata_o    <= tl_i.a_data;
            be_o       <= tl_i.a_mask;
            tmo_cnt_q  <= '0;
            if (proto_err) begin
              state_q   <= RESP;
              d_valid_q <= 1'b1;
              d_error_q <= 1'b1;
              d_data_q  <= {32{a_get}};
            end else begin
              state_q <= ACCESS;
              re_o    <= a_get;
              we_o    <= !a_get;
            end
          end
        end
        ACCESS: begin
          if (!busy_i) begin
            re_o      <= 1'b0;
            we_o      <= 1'b0;
            state_q   <= RESP;
            d_valid_q <= 1'b1;
            d_error_q <= error_i;
            d_data_q  <= !is_get_q ? 32'h0 : (error_i ? 32'hFFFF_FFFF : rdata_i);
          end else if (tmo_cnt_q == TmoLast) begin
            re_o      <= 1'b0;
            we_o      <= 1'b0;
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
            state_q   <= RESP;
            d_valid_q <= 1'b1;
            d_error_q <= 1'b1;
            d_data_q  <= {32{is_get_q}};
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        RESP: begin
          if (tl_i.d_ready) begin
            d_valid_q <= 1'b0;
            d_error_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_param  = 3'h0;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = d_data_q;
    tl_o.d_user   = TlUserDefault;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = (state_q == IDLE);
  end

endmodule

// File: doc/tlul_peri_responder.md
# tlul_peri_responder

TL-UL device endpoint on the 24 MHz peripheral side of `xbar_peri`. It terminates one xbar device port and converts each accepted request into a single register-bus strobe for a peripheral register file. It returns exactly one D-channel response per request, with protocol checking, wait-state support and an access timeout. It is the responder at the far end of the path that `tlul_cdc_adapter` drives into the peripheral domain.

## Interface
- `AW`, default 12: register window address bits.
- `TimeoutCycles`, default 255: maximum `busy_i` wait cycles before the access is aborted; range 1..65535.
- `clk_i` in 1: peripheral clock.
- `rst_ni` in 1: reset; one clock, asynchronous, active-low.
- `tl_i` in `tlul_pkg::tl_h2d_t`: A channel and `d_ready` from `xbar_peri`.
- `tl_o` out `tlul_pkg::tl_d2h_t`: D channel and `a_ready` to `xbar_peri`.
- `re_o` out 1: register read strobe.
- `we_o` out 1: register write strobe.
- `addr_o` out AW: word-aligned register address, bits [1:0] = 0.
- `wdata_o` out 32: write data.
- `be_o` out 4: byte enables, equal to `a_mask`.
- `busy_i` in 1: device wait state; extends the current strobe.
- `rdata_i` in 32: read data, sampled on the completing cycle.
- `error_i` in 1: device error, sampled on the completing cycle.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- Only one transaction is in flight at a time.
- `a_ready` = (state == IDLE).
- **IDLE:**
  - On `a_valid && a_ready`, latch `a_opcode`, `a_size`, `a_source`, `a_address`, `a_mask` and `a_data`.
  - Run the request checks listed below.
  - No check fails → ACCESS.
  - Any check fails → RESP with the error set and no strobe issued.
- **Request checks.** A check fails when any of these holds:
  - opcode not in {PutFullData=0, PutPartialData=1, Get=4};
  - `a_size` > 2;
  - address not aligned to 2^`a_size`;
  - mask has bits outside the lanes selected by `a_size` and `a_address[1:0]`;
  - PutFullData whose mask is not exactly those lanes.
- **ACCESS:**
  - `re_o` = 1 for Get; `we_o` = 1 for Put.
  - The strobe holds while `busy_i` = 1.
  - The first cycle with `busy_i` = 0 completes the access: capture `rdata_i` and `error_i`, then → RESP.
  - `addr_o`, `wdata_o` and `be_o` stay stable for the whole of ACCESS.
- **Timeout:**
  - A 16-bit counter clears on entry to ACCESS and increments on each `busy_i` = 1 cycle.
  - When the counter reaches `TimeoutCycles` with `busy_i` still 1, drop the strobe, → RESP with the error set.
- **RESP:**
  - `d_valid` = 1, with all D fields held constant until `d_ready`.
  - On `d_valid && d_ready` → IDLE.
- **D fields:**
  - `d_opcode` is AccessAckData(1) for Get, including errored Get; it is AccessAck(0) otherwise.
  - `d_source` and `d_size` echo the request.
  - `d_param` = 0, `d_sink` = 0, `d_user` = default.
  - `d_error` = protocol error | `error_i` | timeout.
  - `d_data`:
    - `rdata_i` for a successful Get;
    - 32'hFFFF_FFFF for an errored Get;
    - 0 for writes.

## Timing
- **Reset values:**
  - state IDLE; `a_ready` = 1;
  - `d_valid`, `d_error`, `re_o`, `we_o` = 0;
  - `addr_o`, `wdata_o`, `be_o`, `d_data`, `d_source`, `d_size` = 0;
  - timeout counter = 0.
- **Latency:**
  - Accept at edge N; strobe high in cycle N+1.
  - With `busy_i` = 0, `d_valid` is high in cycle N+2.
  - Each `busy_i` cycle adds one cycle.
  - A protocol error gives `d_valid` in cycle N+1 and no strobe.
- **Throughput:** at best one transaction per 3 cycles, since `a_ready` is low in ACCESS and RESP.
- **Strobes:** `re_o` and `we_o` are never high together, and never high outside ACCESS.
- **Timeout boundary:** a completion (`busy_i` = 0) in the same cycle the counter would hit `TimeoutCycles` is a normal completion, not a timeout.
- **D-channel stall:** `d_ready` low in RESP holds every D field and keeps `a_ready` low indefinitely. No timeout applies in RESP.
- **Reset mid-operation:**
  - Asserting `rst_ni` clears all state immediately and drops the strobes and `d_valid` asynchronously.
  - The in-flight transaction is discarded with no response.
- **`a_valid` outside IDLE:** ignored; nothing is latched.

## Test plan
- **Get, no wait:** Get at `a_address` 0x10, `a_size` 2, mask 0xF, source 5; `rdata_i` = 0xCAFE_F00D.
  - `re_o` is high in cycle N+1 with `addr_o` 0x010.
  - `d_valid` is high in N+2: opcode 1, data 0xCAFE_F00D, source 5, `d_error` 0.
- **Partial write, 3 busy cycles:** PutPartialData at 0x22, size 1, mask 0xC, data 0x1234_0000.
  - `we_o` is high for 4 cycles with `be_o` 0xC.
  - D opcode 0, `d_error` 0, data 0.
- **Protocol errors:**
  - Opcode 2: response in N+1, no strobe, `d_error` 1, opcode 0.
  - Get at 0x3, size 2: no strobe, `d_error` 1, data 0xFFFF_FFFF.
  - PutFullData, size 2, mask 0x7: no strobe, `d_error` 1.
- **Timeout:** `TimeoutCycles` 4, `busy_i` held 1 on a Get.
  - Strobe drops after 4 busy cycles.
  - `d_error` 1, data 0xFFFF_FFFF.
  - A following request completes normally.
- **Device error and backpressure:**
  - `error_i` = 1 on completion gives `d_error` 1.
  - Hold `d_ready` low for 10 cycles: D fields stay stable and `a_ready` stays low.
  - `d_ready` then going high returns the FSM to IDLE.
- **Async reset mid-ACCESS:** pulse `rst_ni` low during a busy write.
  - `we_o` drops without waiting for a clock edge.
  - No response is issued, and all outputs are at their reset values.
